h_decoder_secded_pipe: RTL and testbench
========================================

H_DECODER_SECDED_PIPE -- requirements
Module: h_decoder_secded_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data bits per word, legal range 8..64.
REQ-002 SHALL have parameter CNT_W, default 16: width of each error counter, legal range 2..32.
REQ-003 SHALL have derived constants R (smallest r with 2^r >= DATA_W+r+1; R=6 at 32) and CW_W = DATA_W+R+1 (39 at 32).
REQ-004 i_Clk  in  1  sole clock; all state on rising edge.
REQ-005 i_Rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_CodeWord  in  CW_W  received SECDED codeword.
REQ-007 i_Valid  in  1  i_CodeWord is valid this cycle.
REQ-008 o_Ready  out  1  decoder accepts a word this cycle.
REQ-009 o_DecodWord  out  DATA_W  corrected data.
REQ-010 o_ErrorC  out  1  single error corrected in this word.
REQ-011 o_ErrorD  out  1  uncorrectable error detected in this word.
REQ-012 o_Valid  out  1  output word valid.
REQ-013 i_Ready  in  1  downstream accepts the output word.
REQ-014 i_CntClr  in  1  synchronous clear of both counters.
REQ-015 o_CorrCnt / o_DetCnt  out  CNT_W each  saturating counts of corrected / detected words.

Function
REQ-016 Code layout SHALL be: bit 0 = overall parity, making the XOR of all CW_W bits 0; bits 2^k (k=0..R-1) = Hamming parity; data bits fill the remaining positions 3,5,6,7,9,... in ascending order, LSB first.
REQ-017 Syndrome S[R-1:0] SHALL be the XOR of the indices of all set bits in positions 1..CW_W-1; overall flag P = XOR of all CW_W bits.
REQ-018 Classification: S=0,P=0 -> clean; P=1 and S<CW_W -> flip bit S (S=0 flips bit 0), o_ErrorC=1; P=0,S!=0 -> o_ErrorD=1, data passed uncorrected; P=1,S>=CW_W -> o_ErrorD=1, data uncorrected.
REQ-019 o_ErrorC and o_ErrorD SHALL never both be 1.
REQ-020 Pipeline SHALL be two register stages: stage 1 registers codeword plus S and P; stage 2 registers corrected data and flags; latency SHALL be exactly 2 cycles from accepted input to o_Valid with no backpressure.
REQ-021 Input handshake completes when i_Valid and o_Ready are both high; output handshake completes when o_Valid and i_Ready are both high.
REQ-022 A stage SHALL load when it is empty or its contents move downstream in the same cycle; o_Ready = stage-1 free by this rule; full throughput of one word per cycle SHALL be sustained while i_Ready=1.
REQ-023 While o_Valid=1 and i_Ready=0, o_DecodWord, o_ErrorC and o_ErrorD SHALL hold stable.
REQ-024 Counters SHALL increment once per completed output handshake carrying the matching flag, and saturate at 2^CNT_W-1.
REQ-025 i_CntClr SHALL take priority over a same-cycle increment: the counter reads 0 on the next cycle.

Reset
REQ-026 While i_Rst_n=0: both stages empty; o_Valid=0, o_DecodWord=0, o_ErrorC=0, o_ErrorD=0, counters=0; o_Ready=1 on the first clock edge after release.
REQ-027 Reset asserted mid-stream SHALL discard words in flight with no partial output.

Configuration
REQ-028 Macro H_DEC_ERR_COUNT_EN SHALL compile the counters in; when undefined, o_CorrCnt and o_DetCnt SHALL be tied to 0, i_CntClr ignored, and datapath timing unchanged.

Structure
REQ-029 Package h_code_pkg SHALL hold the R/CW_W derivation functions, the data-to-position map function, and a decode-status enum (CLEAN, CORR, DET).
REQ-030 Combinational sub-module h_syndrome_calc (parameter DATA_W; codeword in, S and P out) SHALL compute the syndrome and overall flag.

Verification (DATA_W=32, CNT_W=4, H_DEC_ERR_COUNT_EN defined)
REQ-031 Clean encoding of 0xDEADBEEF -> 0xDEADBEEF two cycles later, C=0, D=0.
REQ-032 Same word with bit 5 flipped -> 0xDEADBEEF, C=1, D=0; with bit 0 flipped -> 0xDEADBEEF, C=1, o_CorrCnt increments each time.
REQ-033 Bits 3 and 10 flipped -> D=1, C=0, data = uncorrected extraction; o_DetCnt=1.
REQ-034 Back-to-back stream of 8 words with i_Ready low for cycles 3-5 -> all 8 outputs in order, no loss or duplicates, outputs stable while stalled, o_Ready low only while both stages are full.
REQ-035 20 single-error words -> o_CorrCnt saturates at 15; i_CntClr pulsed together with a valid corrected output -> counter reads 0.
REQ-036 i_Rst_n asserted with two words in flight -> o_Valid=0 immediately, and after release the next input decodes correctly with latency 2.

Source files
------------

// File: rtl/h_code_pkg.sv
// Shared constants and helpers for the Hamming SECDED decoder: code-size
// derivation, data-bit placement and the decode status type.
package h_code_pkg;

  // Widest codeword any legal DATA_W can produce fits in this many bits.
  localparam int unsigned MAX_CW_W = 128;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    CORR  = 2'd1,
    DET   = 2'd2
  } dec_status_e;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int unsigned calc_r(int unsigned data_w);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < (data_w + r + 1)) r++;
    return r;
  endfunction

  function automatic int unsigned calc_cw_w(int unsigned data_w);
    return data_w + calc_r(data_w) + 1;
  endfunction

  // Codeword position of data bit idx: positions 3,5,6,7,9,... (non powers of two).
  function automatic int unsigned data_pos(int unsigned idx);
    int unsigned pos;
    int unsigned cnt;
    pos = 0;
    cnt = 0;
    for (int unsigned p = 3; p < MAX_CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Positions 1..MAX_CW_W-1 whose index has bit k set; bit 0 never participates.
  function automatic logic [MAX_CW_W-1:0] syn_mask(int unsigned k);
    logic [MAX_CW_W-1:0] m;
    m = '0;
    for (int p = 1; p < MAX_CW_W; p++) m[p] = p[k];
    return m;
  endfunction

endpackage

// File: rtl/h_syndrome_calc.sv
// Combinational syndrome and overall-parity calculation for a SECDED codeword.
module h_syndrome_calc
  import h_code_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned R     = calc_r(DATA_W),
  localparam int unsigned CW_W  = calc_cw_w(DATA_W)
) (
  input  logic [CW_W-1:0] cw,
  output logic [R-1:0]    syn,
  output logic            par
);

  // Syndrome bit k is the parity of every position whose index has bit k set.
  for (genvar k = 0; k < R; k++) begin : g_syn
    localparam logic [MAX_CW_W-1:0] Mask = syn_mask(k);
    assign syn[k] = ^(cw & Mask[CW_W-1:0]);
  end

  assign par = ^cw;

endmodule

// File: rtl/h_decoder_secded_pipe.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshakes.
// Stage 1 holds the codeword with its syndrome, stage 2 the corrected data.
// Optional error counters are built when H_DEC_ERR_COUNT_EN is defined.
module h_decoder_secded_pipe
  import h_code_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned R     = calc_r(DATA_W),
  localparam int unsigned CW_W  = calc_cw_w(DATA_W)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [CW_W-1:0]   i_CodeWord,
  input  logic              i_Valid,
  output logic              o_Ready,
  output logic [DATA_W-1:0] o_DecodWord,
  output logic              o_ErrorC,
  output logic              o_ErrorD,
  output logic              o_Valid,
  input  logic              i_Ready,
  input  logic              i_CntClr,
  output logic [CNT_W-1:0]  o_CorrCnt,
  output logic [CNT_W-1:0]  o_DetCnt
);

  logic [R-1:0]      syn_in;
  logic              par_in;
  logic              s1_valid_q, s2_valid_q;
  logic [CW_W-1:0]   s1_cw_q;
  logic [R-1:0]      s1_syn_q;
  logic              s1_par_q;
  logic [DATA_W-1:0] s2_data_q;
  logic              s2_c_q, s2_d_q;
  logic              s1_free, s2_free;
  dec_status_e       dec_st;
  logic [CW_W-1:0]   corr_cw;
  logic [DATA_W-1:0] dec_data;
  logic              unused_corr_cw;

  h_syndrome_calc #(
    .DATA_W (DATA_W)
  ) u_syndrome (
    .cw  (i_CodeWord),
    .syn (syn_in),
    .par (par_in)
  );

  // A stage may load when empty or when its word leaves in the same cycle.
  assign s2_free = !s2_valid_q || i_Ready;
  assign s1_free = !s1_valid_q || s2_free;
  assign o_Ready = s1_free;

  // Stage 1: capture codeword with its syndrome and overall parity.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (s1_free) begin
      s1_valid_q <= i_Valid;
      if (i_Valid) begin
        s1_cw_q  <= i_CodeWord;
        s1_syn_q <= syn_in;
        s1_par_q <= par_in;
      end
    end
  end

  // Classify the stage-1 word and flip the erroneous bit when correctable.
  always_comb begin
    dec_st  = CLEAN;
    corr_cw = s1_cw_q;
    if (s1_par_q) begin
      if (32'(s1_syn_q) < CW_W) begin
        corr_cw = s1_cw_q ^ (CW_W'(1) << s1_syn_q);
        dec_st  = CORR;
      end else begin
        dec_st = DET;
      end
    end else if (s1_syn_q != '0) begin
      dec_st = DET;
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_extract
    localparam int unsigned Pos = data_pos(i);
    assign dec_data[i] = corr_cw[Pos];
  end

  // Parity positions are not part of the data word.
  assign unused_corr_cw = ^corr_cw;

  // Stage 2: register corrected data and flags; holds while stalled.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_c_q     <= 1'b0;
      s2_d_q     <= 1'b0;
    end else if (s2_free) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= dec_data;
        s2_c_q    <= (dec_st == CORR);
        s2_d_q    <= (dec_st == DET);
      end
    end
  end

  assign o_Valid     = s2_valid_q;
  assign o_DecodWord = s2_data_q;
  assign o_ErrorC    = s2_c_q;
  assign o_ErrorD    = s2_d_q;

`ifdef H_DEC_ERR_COUNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;
  logic             out_hs;
  logic [CNT_W-1:0] corr_cnt_q, det_cnt_q;

  assign out_hs = s2_valid_q && i_Ready;

  // Saturating counters, one step per delivered word; clear wins over increment.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      corr_cnt_q <= '0;
      det_cnt_q  <= '0;
    end else if (i_CntClr) begin
      corr_cnt_q <= '0;
      det_cnt_q  <= '0;
    end else if (out_hs) begin
      if (s2_c_q && (corr_cnt_q != CntMax)) corr_cnt_q <= corr_cnt_q + CNT_W'(1);
      if (s2_d_q && (det_cnt_q != CntMax))  det_cnt_q  <= det_cnt_q + CNT_W'(1);
    end
  end

  assign o_CorrCnt = corr_cnt_q;
  assign o_DetCnt  = det_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_CntClr;
  assign o_CorrCnt      = '0;
  assign o_DetCnt       = '0;
`endif

endmodule

// File: tb/tb_h_decoder_secded_pipe.sv
// Directed self-checking bench for h_decoder_secded_pipe (DATA_W=32, CNT_W=4).
// Counter expectations follow H_DEC_ERR_COUNT_EN (zero when it is undefined).
module tb_h_decoder_secded_pipe;

  localparam int unsigned DW  = 32;
  localparam int unsigned CNW = 4;
  localparam int unsigned CWW = 39;
`ifdef H_DEC_ERR_COUNT_EN
  localparam int SatExp = 15;
`else
  localparam int SatExp = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [CWW-1:0] i_CodeWord;
  logic           i_Valid, i_Ready, i_CntClr;
  logic           o_Ready, o_ErrorC, o_ErrorD, o_Valid;
  logic [DW-1:0]  o_DecodWord;
  logic [CNW-1:0] o_CorrCnt, o_DetCnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_corr = 0;
  int exp_det  = 0;

  logic [CWW-1:0] cw_tmp;
  logic [DW-1:0]  words [8];
  int             sent, recv;
  logic           in_hs, out_hs, held;
  logic [DW-1:0]  held_data;

  h_decoder_secded_pipe #(
    .DATA_W (DW),
    .CNT_W  (CNW)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_CodeWord  (i_CodeWord),
    .i_Valid     (i_Valid),
    .o_Ready     (o_Ready),
    .o_DecodWord (o_DecodWord),
    .o_ErrorC    (o_ErrorC),
    .o_ErrorD    (o_ErrorD),
    .o_Valid     (o_Valid),
    .i_Ready     (i_Ready),
    .i_CntClr    (i_CntClr),
    .o_CorrCnt   (o_CorrCnt),
    .o_DetCnt    (o_DetCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Reference encoder: data in non-power-of-two slots, Hamming then overall parity.
  function automatic logic [CWW-1:0] enc(input logic [DW-1:0] d);
    logic [CWW-1:0] c;
    int             j;
    logic           x;
    c = '0;
    j = 0;
    for (int p = 1; p < CWW; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      x = 1'b0;
      for (int p = 1; p < CWW; p++) if (p[k]) x = x ^ c[p];
      c[1 << k] = x;
    end
    c[0] = ^c[CWW-1:1];
    return c;
  endfunction

  // One isolated word: checks exact latency, the decoded output and the counters.
  task automatic xfer(input string tag, input logic [CWW-1:0] cw, input logic [DW-1:0] ed,
                      input logic ec, input logic edet, input logic clr);
    i_CodeWord = cw;
    i_Valid    = 1'b1;
    #1;
    check({tag, "_rdy"}, o_Ready, 1);
    @(posedge clk); #1;
    i_Valid = 1'b0;
    check({tag, "_lat1"}, o_Valid, 0);
    @(posedge clk); #1;
    check({tag, "_vld"}, o_Valid, 1);
    check({tag, "_data"}, o_DecodWord, ed);
    check({tag, "_c"}, o_ErrorC, ec);
    check({tag, "_d"}, o_ErrorD, edet);
    i_CntClr = clr;
    @(posedge clk); #1;
    i_CntClr = 1'b0;
`ifdef H_DEC_ERR_COUNT_EN
    if (clr) begin
      exp_corr = 0;
      exp_det  = 0;
    end else begin
      if (ec && exp_corr < 15) exp_corr++;
      if (edet && exp_det < 15) exp_det++;
    end
`endif
    check({tag, "_ccnt"}, o_CorrCnt, exp_corr);
    check({tag, "_dcnt"}, o_DetCnt, exp_det);
    check({tag, "_drain"}, o_Valid, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    i_CodeWord = '0;
    i_Valid    = 1'b0;
    i_Ready    = 1'b1;
    i_CntClr   = 1'b0;
    #2;
    check("rst_valid", o_Valid, 0);
    check("rst_data", o_DecodWord, 0);
    check("rst_flags", {o_ErrorC, o_ErrorD}, 0);
    check("rst_cnt", {o_CorrCnt, o_DetCnt}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", o_Ready, 1);

    xfer("clean", enc(32'hDEADBEEF), 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    xfer("zero", enc(32'h0000_0000), 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    cw_tmp = enc(32'hDEADBEEF); cw_tmp[5] = ~cw_tmp[5];
    xfer("flip5", cw_tmp, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    cw_tmp = enc(32'hDEADBEEF); cw_tmp[0] = ~cw_tmp[0];
    xfer("flip0", cw_tmp, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    cw_tmp = enc(32'hFFFFFFFF); cw_tmp[38] = ~cw_tmp[38];
    xfer("flip38", cw_tmp, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    // Positions 3 and 10 carry data bits 0 and 5: S=9, P=0.
    cw_tmp = enc(32'hDEADBEEF); cw_tmp[3] = ~cw_tmp[3]; cw_tmp[10] = ~cw_tmp[10];
    xfer("dbl", cw_tmp, 32'hDEADBECE, 1'b0, 1'b1, 1'b0);
    // Flips at 32, 8 and 0: S=40 beyond the codeword with P=1, data untouched.
    cw_tmp = enc(32'hDEADBEEF); cw_tmp[32] = ~cw_tmp[32]; cw_tmp[8] = ~cw_tmp[8];
    cw_tmp[0] = ~cw_tmp[0];
    xfer("srange", cw_tmp, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);

    // Back-to-back stream with downstream stalled on cycles 3..5.
    for (int i = 0; i < 8; i++) words[i] = 32'hA5A5_0000 + i * 32'h0000_1111;
    sent = 0;
    recv = 0;
    held = 1'b0;
    held_data = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      i_Ready = !(cyc >= 3 && cyc <= 5);
      i_Valid = (sent < 8);
      if (sent < 8) i_CodeWord = enc(words[sent]);
      #1;
      if (held) begin
        check("stall_valid", o_Valid, 1);
        check("stall_data", o_DecodWord, held_data);
        check("stall_flags", {o_ErrorC, o_ErrorD}, 0);
      end
      check("strm_rdy", o_Ready, !((sent - recv) == 2 && !i_Ready));
      in_hs  = i_Valid && o_Ready;
      out_hs = o_Valid && i_Ready;
      if (out_hs) begin
        check("strm_data", o_DecodWord, words[recv]);
        check("strm_flags", {o_ErrorC, o_ErrorD}, 0);
      end
      held      = o_Valid && !i_Ready;
      held_data = o_DecodWord;
      @(posedge clk); #1;
      if (in_hs) sent++;
      if (out_hs) recv++;
    end
    i_Valid = 1'b0;
    i_Ready = 1'b1;
    check("strm_count", recv, 8);
    check("strm_empty", o_Valid, 0);

    // Twenty single-bit errors drive the correction counter into saturation.
    for (int i = 0; i < 20; i++) begin
      cw_tmp = enc(32'h12345678);
      cw_tmp[i + 1] = ~cw_tmp[i + 1];
      xfer("sat", cw_tmp, 32'h12345678, 1'b1, 1'b0, 1'b0);
    end
    check("corr_sat", o_CorrCnt, SatExp);
    cw_tmp = enc(32'h12345678); cw_tmp[7] = ~cw_tmp[7];
    xfer("clr", cw_tmp, 32'h12345678, 1'b1, 1'b0, 1'b1);
    check("clr_zero", o_CorrCnt, 0);

    // Reset with two words in flight, then a fresh word must decode normally.
    i_Valid = 1'b1;
    i_CodeWord = enc(32'hCAFEF00D);
    @(posedge clk); #1;
    i_CodeWord = enc(32'h0BADC0DE);
    @(posedge clk); #1;
    i_Valid = 1'b0;
    check("mid_full", o_Valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_Valid, 0);
    check("mid_rst_data", o_DecodWord, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_corr = 0;
    exp_det  = 0;
    check("mid_rst_hold", o_Valid, 0);
    @(posedge clk); #1;
    check("mid_no_ghost", o_Valid, 0);
    cw_tmp = enc(32'h5A5A_3C3C); cw_tmp[20] = ~cw_tmp[20];
    xfer("post_rst", cw_tmp, 32'h5A5A_3C3C, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
